// File: rtl/xy_route_unit.sv
`default_nettype none
// ============================================================================
// Module      : xy_route_unit
// Description : Registered XY route-compute and packet-lock stage for one
//               mesh NoC router input port. Decodes the destination of each
//               header flit, selects an output port by XY dimension order,
//               holds that route for the rest of the packet and forwards
//               flits through a one-deep valid/ready pipeline register.
//               Malformed packets and out-of-mesh destinations are dropped
//               and reported.
// Revision    : 1.0 - initial release
// ============================================================================
module xy_route_unit #(
    parameter int X_NODE_NUM       = 4,
    parameter int Y_NODE_NUM       = 4,
    parameter int X_NODE_NUM_WIDTH = 2,
    parameter int Y_NODE_NUM_WIDTH = 2,
    parameter int CUR_X            = 0,
    parameter int CUR_Y            = 0,
    parameter int FLIT_W           = 8
) (
    input  logic              clk,
    input  logic              rst,        // asynchronous, active low
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FLIT_W-1:0] flit_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FLIT_W-1:0] flit_out,
    output logic [3:0]        port_num,
    output logic [4:0]        port_sel,
    output logic              err_pulse,
    output logic [7:0]        drop_cnt
);

    localparam int c_XW = X_NODE_NUM_WIDTH;
    localparam int c_YW = Y_NODE_NUM_WIDTH;

    // Own address widened by one bit so the difference carries a sign bit.
    localparam logic [c_XW:0] c_CUR_X = CUR_X[c_XW:0];
    localparam logic [c_YW:0] c_CUR_Y = CUR_Y[c_YW:0];

    localparam logic [1:0] c_TYPE_HDR    = 2'b10;
    localparam logic [1:0] c_TYPE_TAIL   = 2'b01;

    localparam logic [3:0] c_NUM_L = 4'd1;
    localparam logic [3:0] c_NUM_E = 4'd2;
    localparam logic [3:0] c_NUM_N = 4'd3;
    localparam logic [3:0] c_NUM_W = 4'd4;
    localparam logic [3:0] c_NUM_S = 4'd5;

    localparam logic [4:0] c_SEL_L = 5'b00001;
    localparam logic [4:0] c_SEL_E = 5'b00010;
    localparam logic [4:0] c_SEL_W = 5'b00100;
    localparam logic [4:0] c_SEL_S = 5'b01000;
    localparam logic [4:0] c_SEL_N = 5'b10000;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DROP   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic              r_valid;
    logic [FLIT_W-1:0] r_flit;
    logic [3:0]        r_port_num;
    logic [4:0]        r_port_sel;
    logic              r_err;
    logic [7:0]        r_drop_cnt;

    logic [1:0]        w_type;
    logic [c_XW-1:0]   w_dest_x;
    logic [c_YW-1:0]   w_dest_y;
    logic [c_XW:0]     w_xdiff;
    logic [c_YW:0]     w_ydiff;
    logic              w_dest_ok;
    logic              w_is_head;
    logic              w_is_hdr;
    logic              w_is_tail;
    logic              w_accept;
    logic [3:0]        w_route_num;
    logic [4:0]        w_route_sel;
    logic              w_fwd;
    logic              w_drop;
    logic              w_err;
    logic              w_load_route;

    assign w_type   = flit_in[FLIT_W-1 -: 2];
    assign w_dest_x = flit_in[c_XW+c_YW-1 : c_YW];
    assign w_dest_y = flit_in[c_YW-1:0];

    // Two's-complement differences; the top bit is the sign.
    assign w_xdiff  = {1'b0, w_dest_x} - c_CUR_X;
    assign w_ydiff  = {1'b0, w_dest_y} - c_CUR_Y;

    assign w_dest_ok = (32'(w_dest_x) < X_NODE_NUM) && (32'(w_dest_y) < Y_NODE_NUM);

    // HDR (10) and SINGLE (11) both open a packet.
    assign w_is_head = w_type[1];
    assign w_is_hdr  = (w_type == c_TYPE_HDR);
    assign w_is_tail = (w_type == c_TYPE_TAIL);

    assign in_ready  = !r_valid || out_ready;
    assign w_accept  = in_valid && in_ready;

    // XY dimension-order routing: resolve X first, then Y, else local.
    always_comb begin
        w_route_num = c_NUM_L;
        w_route_sel = c_SEL_L;
        if (!w_xdiff[c_XW] && (w_xdiff != '0)) begin
            w_route_num = c_NUM_E;
            w_route_sel = c_SEL_E;
        end else if (w_xdiff[c_XW]) begin
            w_route_num = c_NUM_W;
            w_route_sel = c_SEL_W;
        end else if (!w_ydiff[c_YW] && (w_ydiff != '0)) begin
            w_route_num = c_NUM_S;
            w_route_sel = c_SEL_S;
        end else if (w_ydiff[c_YW]) begin
            w_route_num = c_NUM_N;
            w_route_sel = c_SEL_N;
        end
    end

    // Packet FSM: decides forward/drop/error for each accepted flit.
    always_comb begin
        w_state_next = r_state;
        w_fwd        = 1'b0;
        w_drop       = 1'b0;
        w_err        = 1'b0;
        w_load_route = 1'b0;
        if (w_accept) begin
            if (w_is_head) begin
                // A head arriving inside a packet means the tail went missing.
                w_err = (r_state != S_IDLE);
                if (w_dest_ok) begin
                    w_fwd        = 1'b1;
                    w_load_route = 1'b1;
                    w_state_next = w_is_hdr ? S_ACTIVE : S_IDLE;
                end else begin
                    w_drop       = 1'b1;
                    w_err        = 1'b1;
                    w_state_next = w_is_hdr ? S_DROP : S_IDLE;
                end
            end else begin
                case (r_state)
                    S_ACTIVE: begin
                        w_fwd = 1'b1;
                        if (w_is_tail) begin
                            w_state_next = S_IDLE;
                        end
                    end
                    S_DROP: begin
                        w_drop = 1'b1;
                        if (w_is_tail) begin
                            w_state_next = S_IDLE;
                        end
                    end
                    default: begin
                        // Body or tail with no open packet.
                        w_drop       = 1'b1;
                        w_err        = 1'b1;
                        w_state_next = S_IDLE;
                    end
                endcase
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Pipeline register: load on forward, otherwise drain when taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_flit  <= '0;
        end else if (w_fwd) begin
            r_valid <= 1'b1;
            r_flit  <= flit_in;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Route register doubles as the packet lock; only heads change it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_port_num <= '0;
            r_port_sel <= '0;
        end else if (w_fwd && w_load_route) begin
            r_port_num <= w_route_num;
            r_port_sel <= w_route_sel;
        end
    end

    // Error pulse and saturating drop counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err      <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_err <= w_err;
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    assign out_valid = r_valid;
    assign flit_out  = r_flit;
    assign port_num  = r_port_num;
    assign port_sel  = r_port_sel;
    assign err_pulse = r_err;
    assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: doc/xy_route_unit.md
Name: xy_route_unit

Overview:
- Parametrised, registered XY route-compute and packet-lock stage for one router input port in the mesh NoC.
- Decodes destination X/Y from each header flit, picks an output port by XY dimension order, and holds that route for the body and tail flits.
- Forwards flits through a one-deep valid/ready pipeline register.
- Reports protocol and destination errors; replaces the per-router combinational compute blocks (one instance per port, any router position).

Parameters:
- X_NODE_NUM, 4, mesh columns
- Y_NODE_NUM, 4, mesh rows
- X_NODE_NUM_WIDTH, 2, dest X field width
- Y_NODE_NUM_WIDTH, 2, dest Y field width
- CUR_X, 0, this router's X address
- CUR_Y, 0, this router's Y address
- FLIT_W, 8, flit width; must be >= X_NODE_NUM_WIDTH + Y_NODE_NUM_WIDTH + 2

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- in_valid  in  1  upstream flit valid
- in_ready  out  1  flit accepted when in_valid & in_ready
- flit_in  in  FLIT_W  [FLIT_W-1:FLIT_W-2] type; [X_W+Y_W-1:Y_W] dest X; [Y_W-1:0] dest Y
- out_valid  out  1  registered flit valid
- out_ready  in  1  downstream accepts
- flit_out  out  FLIT_W  registered flit
- port_num  out  4  1=L, 2=E, 3=N, 4=W, 5=S, 0=none
- port_sel  out  5  one-hot: bit0 L, bit1 E, bit2 W, bit3 S, bit4 N
- err_pulse  out  1  one-cycle pulse on protocol/destination error
- drop_cnt  out  8  saturating count of dropped flits

Behaviour:
- Reset (rst=0, async): out_valid=0, flit_out=0, port_num=0, port_sel=0, err_pulse=0, drop_cnt=0, state=IDLE. Mid-packet reset discards the lock and any held flit.
- Flit types: 2'b10 HDR, 2'b00 BODY, 2'b01 TAIL, 2'b11 SINGLE (header and tail in one flit).
- in_ready = !out_valid | out_ready. The pipeline register loads on accept. Latency: 1 cycle from accept to out_valid.
- Route compute uses signed (W+1)-bit diffs: xdiff = xd - CUR_X, ydiff = yd - CUR_Y.
  - xdiff>0 gives E; xdiff<0 gives W.
  - Otherwise ydiff>0 gives S, ydiff<0 gives N, else L.
- port_num/port_sel are registered alongside flit_out and stay constant for every flit of a locked packet.
- FSM states IDLE, ACTIVE, DROP. Transitions apply only on an accepted flit:
  - IDLE + HDR, dest valid: compute route, lock, forward, go to ACTIVE.
  - IDLE + SINGLE, dest valid: compute route, forward, stay IDLE.
  - IDLE + HDR/SINGLE, dest out of range (xd>=X_NODE_NUM or yd>=Y_NODE_NUM): drop, err_pulse, drop_cnt+1. HDR goes to DROP; SINGLE stays IDLE.
  - IDLE + BODY/TAIL (orphan): drop, err_pulse, drop_cnt+1, stay IDLE.
  - ACTIVE + BODY: forward on the locked route.
  - ACTIVE + TAIL: forward, release the lock, go to IDLE.
  - ACTIVE + HDR/SINGLE (missing tail): err_pulse, no drop. Re-route as from IDLE; if its dest is invalid, apply the IDLE invalid-dest rule.
  - DROP + BODY: drop, count.
  - DROP + TAIL: drop, count, go to IDLE.
  - DROP + HDR/SINGLE: handle as in IDLE, plus err_pulse.
- A dropped flit is accepted (in_ready rules unchanged) but does not set out_valid. When the register is not being reloaded, out_valid clears on out_ready.
- drop_cnt saturates at 255.
- Backpressure: while out_valid & !out_ready, the held flit, port_num and port_sel stay stable, and in_ready=0.
- Simultaneous accept and downstream take in one cycle: the register reloads, and out_valid stays 1 if the new flit is forwarded.

Test Plan:
- CUR=(0,0); headers flit_in=8'b10_00_1000 (X=2,Y=0) and 8'b10_00_0011 (X=0,Y=3) -> port_num 2 (E), port_sel 00010 then port_num 5 (S), port_sel 01000; each 1 cycle after accept.
- CUR=(2,2); SINGLE flits to (1,3), (2,1), (2,2) -> W(4, 00100), N(3, 10000), L(1, 00001); FSM stays IDLE.
- HDR to (3,0), 3 BODY, TAIL, with out_ready held 0 for 2 cycles mid-packet -> all 5 flits out in order, route E throughout, no loss or duplication; FSM returns to IDLE after the tail.
- X_NODE_NUM=3; HDR to (3,0), BODY, TAIL -> err_pulse once, drop_cnt=3, out_valid never set. A following valid header routes normally.
- Orphan BODY in IDLE -> err_pulse, drop_cnt=1. HDR mid-packet -> err_pulse, new route locked, flit forwarded.
- Assert rst mid-packet while out_valid=1 -> out_valid, port_sel, drop_cnt =0 immediately. A following BODY is treated as orphan.
